// File: rtl/md_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | md_defs : shared encodings and defaults for the multiply/divide unit |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package md_defs;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Ops that occupy the unit for a multi-cycle busy period.
  function automatic logic is_long_op(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd4);
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | md_unit_if : EX-stage request and HI/LO/status bundle for md_unit    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface md_unit_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, rs_val, rt_val,
    input  busy, stall_req, hi, lo
  );

  modport slave (
    input  start, md_op, rs_val, rt_val,
    output busy, stall_req, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/md_unit_arith.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | md_arith : combinational 32x32 multiply and 32/32 divide datapath    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module md_arith
  import md_defs::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] cur_hi,
  input  logic [31:0] cur_lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_div_u;
  logic [31:0] w_div_s;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_sq_mag;
  logic [31:0] w_sr_mag;
  logic [31:0] w_sq;
  logic [31:0] w_sr;

  // Low 64 bits of the sign-extended product equal the signed product.
  assign w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign w_prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide via magnitudes avoids the 0x80000000 / -1 overflow case.
  assign w_mag_a = a[31] ? (~a + 32'd1) : a;
  assign w_mag_b = b[31] ? (~b + 32'd1) : b;

  assign w_div_u  = (b == 32'd0) ? 32'd1 : b;
  assign w_div_s  = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
  assign w_uq     = a / w_div_u;
  assign w_ur     = a % w_div_u;
  assign w_sq_mag = w_mag_a / w_div_s;
  assign w_sr_mag = w_mag_a % w_div_s;
  assign w_sq     = (a[31] ^ b[31]) ? (~w_sq_mag + 32'd1) : w_sq_mag;
  assign w_sr     = a[31] ? (~w_sr_mag + 32'd1) : w_sr_mag;

  always_comb begin
    res_hi = cur_hi;
    res_lo = cur_lo;
    case (op)
      MD_MULT:  {res_hi, res_lo} = w_prod_s;
      MD_MULTU: {res_hi, res_lo} = w_prod_u;
      MD_DIV: begin
        if (b != 32'd0) begin
          res_hi = w_sr;
          res_lo = w_sq;
        end
      end
      MD_DIVU: begin
        if (b != 32'd0) begin
          res_hi = w_ur;
          res_lo = w_uq;
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | md_unit : EX-stage multiply/divide unit with HI/LO and stall control |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module md_unit
  import md_defs::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  md_unit_if.slave   bus
);

  localparam logic [3:0] C_MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] C_DIV_CNT  = 4'(DIV_CYCLES);

  md_state_e   r_state;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_p_hi;
  logic [31:0] r_p_lo;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic        w_long_op;
  logic        w_is_mult;

  assign w_long_op = is_long_op(bus.md_op);
  assign w_is_mult = (bus.md_op == MD_MULT) || (bus.md_op == MD_MULTU);

  md_arith u_arith (
    .op     (bus.md_op),
    .a      (bus.rs_val),
    .b      (bus.rt_val),
    .cur_hi (r_hi),
    .cur_lo (r_lo),
    .res_hi (w_res_hi),
    .res_lo (w_res_lo)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_busy  <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_p_hi  <= 32'd0;
      r_p_lo  <= 32'd0;
    end else if (r_state == ST_IDLE) begin
      if (bus.start) begin
        if (w_long_op) begin
          r_p_hi  <= w_res_hi;
          r_p_lo  <= w_res_lo;
          r_cnt   <= w_is_mult ? C_MULT_CNT : C_DIV_CNT;
          r_busy  <= 1'b1;
          r_state <= ST_RUN;
        end else if (bus.md_op == MD_MTHI) begin
          r_hi <= bus.rs_val;
        end else if (bus.md_op == MD_MTLO) begin
          r_lo <= bus.rs_val;
        end
      end
    end else begin
      // Any start seen while running is dropped; the hazard unit prevents it.
      if (r_cnt == 4'd1) begin
        r_hi    <= r_p_hi;
        r_lo    <= r_p_lo;
        r_busy  <= 1'b0;
        r_cnt   <= 4'd0;
        r_state <= ST_IDLE;
      end else begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.stall_req = r_busy | (bus.start & w_long_op);
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_md_unit : scoreboard bench for md_unit                            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_md_unit;
  import md_defs::*;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  logic [63:0] exp_q[$];

  md_unit_if bus();

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, act, exp);
    end
  endtask

  // Issues a long op, optionally pokes an mtlo in busy cycle `inject`,
  // then measures the busy window and scores the resulting HI/LO.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [63:0] exp, input int inject);
    int cyc;
    logic stall_ok;
    logic [63:0] want;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.md_op  = op;
    bus.rs_val = a;
    bus.rt_val = b;
    #1 check({tag, " stall_start"}, {63'd0, bus.stall_req}, 64'd1);
    exp_q.push_back(exp);
    @(negedge clk);
    bus.start = 1'b0;
    bus.md_op = MD_NONE;
    cyc = 0;
    stall_ok = 1'b1;
    while (bus.busy && cyc < 20) begin
      cyc++;
      if (!bus.stall_req) stall_ok = 1'b0;
      if (inject != 0 && cyc == inject) begin
        bus.start  = 1'b1;
        bus.md_op  = MD_MTLO;
        bus.rs_val = 32'hAB;
      end
      @(negedge clk);
      bus.start = 1'b0;
      bus.md_op = MD_NONE;
    end
    check({tag, " busy_cycles"}, 64'(cyc), 64'(n));
    check({tag, " stall_busy"}, {63'd0, stall_ok}, 64'd1);
    want = exp_q.pop_front();
    check({tag, " hilo"}, {bus.hi, bus.lo}, want);
  endtask

  task automatic move_to(input string tag, input logic [2:0] op, input logic [31:0] v,
                         input logic [63:0] exp);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.md_op  = op;
    bus.rs_val = v;
    #1 check({tag, " stall"}, {63'd0, bus.stall_req}, 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.md_op = MD_NONE;
    check({tag, " busy"}, {63'd0, bus.busy}, 64'd0);
    check({tag, " hilo"}, {bus.hi, bus.lo}, exp);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    errors     = 0;
    checks     = 0;
    reset      = 1'b0;
    bus.start  = 1'b0;
    bus.md_op  = MD_NONE;
    bus.rs_val = 32'd0;
    bus.rt_val = 32'd0;
    repeat (2) @(negedge clk);
    check("reset busy", {63'd0, bus.busy}, 64'd0);
    check("reset hilo", {bus.hi, bus.lo}, 64'd0);
    check("reset stall", {63'd0, bus.stall_req}, 64'd0);
    reset = 1'b1;

    run_op("mult", MD_MULT, 32'hFFFFFFFE, 32'd3, 5, 64'hFFFFFFFF_FFFFFFFA, 0);
    run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 64'hFFFFFFFE_00000001, 0);
    run_op("div", MD_DIV, 32'hFFFFFFF9, 32'd2, 10, 64'hFFFFFFFF_FFFFFFFD, 0);
    run_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 64'h00000000_80000000, 0);
    run_op("divu", MD_DIVU, 32'd100, 32'd7, 10, {32'd2, 32'd14}, 0);

    move_to("mthi", MD_MTHI, 32'h11, {32'h11, 32'd14});
    move_to("mtlo", MD_MTLO, 32'h22, {32'h11, 32'h22});
    run_op("divu0", MD_DIVU, 32'd5, 32'd0, 10, {32'h11, 32'h22}, 0);
    run_op("div0", MD_DIV, 32'hFFFFFFF0, 32'd0, 10, {32'h11, 32'h22}, 0);

    run_op("inject", MD_MULT, 32'd6, 32'hFFFFFFFF, 5, 64'hFFFFFFFF_FFFFFFFA, 2);
    move_to("mtlo_after", MD_MTLO, 32'hAB, {32'hFFFFFFFF, 32'hAB});

    for (int i = 0; i < 3; i++) begin
      ra = $urandom;
      rb = $urandom;
      sa = $signed(ra);
      sb = $signed(rb);
      run_op("rnd_mult", MD_MULT, ra, rb, 5, 64'(sa * sb), 0);
      run_op("rnd_multu", MD_MULTU, ra, rb, 5, {32'd0, ra} * {32'd0, rb}, 0);
      rb = rb >> (i * 8);
      rb = rb | 32'd1;
      run_op("rnd_divu", MD_DIVU, ra, rb, 10, {ra % rb, ra / rb}, 0);
    end

    // Asynchronous reset in busy cycle 3 of a div.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.md_op  = MD_DIV;
    bus.rs_val = 32'd100;
    bus.rt_val = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    bus.md_op = MD_NONE;
    repeat (2) @(negedge clk);
    check("abort busy_before", {63'd0, bus.busy}, 64'd1);
    reset = 1'b0;
    #1;
    check("abort busy", {63'd0, bus.busy}, 64'd0);
    check("abort hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check("abort no_write", {bus.hi, bus.lo}, 64'd0);
    check("abort idle", {63'd0, bus.busy}, 64'd0);
    run_op("post_reset", MD_MULT, 32'd3, 32'd4, 5, 64'd12, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
